// File: rtl/nrd_seq_divider.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock through a
// shared WIDTH+1-bit add/subtract, then one remainder-correction cycle.
module nrd_seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      ZERO
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH:0]   a_reg, a_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] d_reg, d_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] quot_reg, quot_next;
   logic [WIDTH-1:0] rem_reg, rem_next;
   logic             dz_reg, dz_next;

   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   a_fix;

   // Single shared datapath: the sign of A chooses add or subtract of D.
   assign d_ext   = {1'b0, d_reg};
   assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign a_step  = a_reg[WIDTH] ? (a_shift + d_ext) : (a_shift - d_ext);
   assign a_fix   = a_reg[WIDTH] ? (a_reg + d_ext) : a_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         quot_reg  <= '0;
         rem_reg   <= '0;
         dz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         q_reg     <= q_next;
         d_reg     <= d_next;
         cnt_reg   <= cnt_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         quot_reg  <= quot_next;
         rem_reg   <= rem_next;
         dz_reg    <= dz_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      q_next     = q_reg;
      d_next     = d_reg;
      cnt_next   = cnt_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      quot_next  = quot_reg;
      rem_next   = rem_reg;
      dz_next    = dz_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               d_next     = divisor;
               q_next     = dividend;
               a_next     = '0;
               cnt_next   = CW'(WIDTH - 1);
               busy_next  = 1'b1;
               state_next = (divisor == '0) ? ZERO : ITER;
            end
         end
         ITER: begin
            a_next = a_step;
            q_next = {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
            if (cnt_reg == '0) begin
               state_next = FIX;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         FIX: begin
            a_next     = a_fix;
            quot_next  = q_reg;
            rem_next   = a_fix[WIDTH-1:0];
            dz_next    = 1'b0;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         ZERO: begin
            // Q still holds the captured dividend here.
            quot_next  = '1;
            rem_next   = q_reg;
            dz_next    = 1'b1;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign quotient    = quot_reg;
   assign remainder   = rem_reg;
   assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_nrd_seq_divider.sv
// Bench for nrd_seq_divider: cycle-level model for the 8-bit instance plus
// directed and random transactions on 4-, 8- and 16-bit instances.
module tb_nrd_seq_divider;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   logic        start8 = 1'b0;
   logic [7:0]  dvd8 = '0, dvs8 = '0;
   logic        busy8, done8, dz8;
   logic [7:0]  q8, r8;

   logic        start4 = 1'b0;
   logic [3:0]  dvd4 = '0, dvs4 = '0;
   logic        busy4, done4, dz4;
   logic [3:0]  q4, r4;

   logic        start16 = 1'b0;
   logic [15:0] dvd16 = '0, dvs16 = '0;
   logic        busy16, done16, dz16;
   logic [15:0] q16, r16;

   nrd_seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
   );
   nrd_seq_divider #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dvd4), .divisor(dvs4),
      .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dz4)
   );
   nrd_seq_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .dividend(dvd16), .divisor(dvs16),
      .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model of the 8-bit instance: a countdown to the result cycle, results by / and %.
   bit         m_busy = 0, m_done = 0, m_dz = 0;
   int         m_cnt = 0;
   logic [7:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_dz = 0; m_cnt = 0;
         m_q = '0; m_r = '0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy = 0;
               m_done = 1;
               if (m_b == 0) begin
                  m_dz = 1; m_q = 8'hFF; m_r = m_a;
               end else begin
                  m_dz = 0; m_q = m_a / m_b; m_r = m_a % m_b;
               end
            end
         end else if (start8) begin
            m_busy = 1;
            m_a    = dvd8;
            m_b    = dvs8;
            m_cnt  = (dvs8 == 0) ? 1 : 9;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy8", busy8, m_busy);
         chk("done8", done8, m_done);
         chk("quot8", q8, m_q);
         chk("rem8", r8, m_r);
         chk("dz8", dz8, m_dz);
      end
   end

   // Counts edges from the accept edge until done; optionally intrudes a start while busy.
   task automatic wait_done8(input int intr, output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (intr > 0 && lat == intr) begin
            start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd2;
         end else if (intr > 0 && lat == intr + 1) begin
            start8 = 1'b0;
         end
      end while (!done8 && lat < 40);
      if (!done8) chk("done8_timeout", 0, 1);
   endtask

   task automatic run8(input int a, input int b, input int eq, input int er,
                       input int edz, input int elat, input int intr);
      int lat;
      @(negedge clk);
      start8 = 1'b1; dvd8 = 8'(a); dvs8 = 8'(b);
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(intr, lat);
      $display("txn w8 %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q8, r8, dz8, lat);
      chk($sformatf("lat8 %0d/%0d", a, b), lat, elat);
      chk($sformatf("quot8 %0d/%0d", a, b), q8, eq);
      chk($sformatf("rem8 %0d/%0d", a, b), r8, er);
      chk($sformatf("dz8 %0d/%0d", a, b), dz8, edz);
   endtask

   task automatic run4(input int a, input int b, input int eq, input int er,
                       input int edz, input int elat);
      int lat;
      @(negedge clk);
      start4 = 1'b1; dvd4 = 4'(a); dvs4 = 4'(b);
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done4 && lat < 40);
      $display("txn w4 %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q4, r4, dz4, lat);
      chk($sformatf("lat4 %0d/%0d", a, b), lat, elat);
      chk($sformatf("quot4 %0d/%0d", a, b), q4, eq);
      chk($sformatf("rem4 %0d/%0d", a, b), r4, er);
      chk($sformatf("dz4 %0d/%0d", a, b), dz4, edz);
      @(posedge clk); #1;
      chk("done4_pulse", done4, 0);
   endtask

   task automatic run16(input int a, input int b, input int eq, input int er,
                        input int edz, input int elat);
      int lat;
      @(negedge clk);
      start16 = 1'b1; dvd16 = 16'(a); dvs16 = 16'(b);
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!done16) chk("busy16_mid", busy16, 1);
      end while (!done16 && lat < 40);
      $display("txn w16 %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, q16, r16, dz16, lat);
      chk($sformatf("lat16 %0d/%0d", a, b), lat, elat);
      chk($sformatf("quot16 %0d/%0d", a, b), q16, eq);
      chk($sformatf("rem16 %0d/%0d", a, b), r16, er);
      chk($sformatf("dz16 %0d/%0d", a, b), dz16, edz);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int eq[3];
      int er[3];
      int a, b;
      eq = '{0, 255, 1};
      er = '{5, 0, 0};

      #3 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_quot8", q8, 0);
      chk("rst_rem8", r8, 0);
      chk("rst_quot4", q4, 0);
      chk("rst_quot16", q16, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 200/7: latency 9, model result pinned by literals
      run8(200, 7, 28, 4, 0, 9, 0);
      chk("model_q 200/7", m_q, 28);
      chk("model_r 200/7", m_r, 4);

      // back-to-back with start held high
      @(negedge clk);
      start8 = 1'b1; dvd8 = 8'd5; dvs8 = 8'd9;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin
            dvd8 = 8'd255; dvs8 = 8'd1;
         end else if (i == 1) begin
            dvd8 = 8'd255; dvs8 = 8'd255;
         end
         wait_done8(0, lat);
         $display("txn w8 b2b #%0d -> q=%0d r=%0d lat=%0d", i, q8, r8, lat);
         chk("b2b_lat", lat, 9);
         chk("b2b_quot", q8, eq[i]);
         chk("b2b_rem", r8, er[i]);
         if (i == 2) begin
            start8 = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      repeat (3) @(negedge clk);

      // divide by zero, then normal division clears the flag
      run8(13, 0, 255, 13, 1, 1, 0);
      run8(13, 3, 4, 1, 0, 9, 0);

      // start while busy is ignored
      run8(100, 9, 11, 1, 0, 9, 3);
      repeat (12) @(negedge clk);

      // asynchronous reset mid-operation
      @(negedge clk);
      start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd9;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy8", busy8, 0);
      chk("arst_done8", done8, 0);
      chk("arst_quot8", q8, 0);
      chk("arst_rem8", r8, 0);
      chk("arst_dz8", dz8, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      run8(100, 9, 11, 1, 0, 9, 0);

      // edge cases
      run8(0, 17, 0, 0, 0, 9, 0);
      run8(37, 1, 37, 0, 0, 9, 0);
      run8(128, 3, 42, 2, 0, 9, 0);

      for (int i = 0; i < 200; i++) begin
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         if (b == 0) run8(a, b, 255, a, 1, 1, 0);
         else run8(a, b, a / b, a % b, 0, 9, 0);
      end

      run4(15, 4, 3, 3, 0, 5);
      run4(15, 15, 1, 0, 0, 5);
      run4(2, 7, 0, 2, 0, 5);
      run4(9, 0, 15, 9, 1, 1);

      run16(65535, 255, 257, 0, 0, 17);
      run16(65535, 65535, 1, 0, 0, 17);
      run16(12345, 1, 12345, 0, 0, 17);
      for (int i = 0; i < 100; i++) begin
         a = $urandom_range(0, 65535);
         b = $urandom_range(1, 65535);
         run16(a, b, a / b, a % b, 0, 17);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
